press_decoder: RTL and testbench
================================

# press_decoder

Receive-side counterpart to the LED blink-pattern generator in the digital lock. It takes the user's raw push-button, synchronises and debounces it, and measures press and gap durations in tenth-second ticks. It counts the presses in one burst and emits the count as a lock-code digit once the button has stayed released for a gap timeout. The lock controller consumes `digit`/`digit_valid` the same way it drives the blinker through `start_blinking`/`done_blinking`.

## Interface
- `TICK_CYCLES`, default 1200000: `hwclk` cycles per 0.1 s tick, the same unit as the blinker's durations.
- `DEBOUNCE_CYCLES`, default 120000: consecutive stable synchronised samples required before the debounced level changes (10 ms).
- `GAP_TICKS`, default 10: released ticks that end a burst (1.0 s).
- `HOLD_TICKS`, default 20: press ticks that count as a hold (2.0 s).
- `hwclk` input 1: system clock. Only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_in` input 1: raw button, active-high, asynchronous to `hwclk`.
- `enable` input 1: controller permits decoding. Low forces IDLE.
- `digit` output 4: press count of the last burst, 1..15. Held until the next emit.
- `digit_valid` output 1: one-cycle pulse, `digit` is new.
- `error` output 1: one-cycle pulse when a burst is aborted (more than 15 presses).
- `clear` output 1: one-cycle hold pulse; exists only under the `_EN` macro.

## Operation
- Input conditioning:
  - `btn_in` passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level `btn_db` toggles only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample zeroes the debounce counter.
- Tick prescaler:
  - Counts 0..`TICK_CYCLES`-1 and emits `tick` on wrap.
  - Zeroed on every `btn_db` edge and in IDLE.
- States:
  - IDLE: wait for a rising edge of `btn_db` with `enable`=1. Then count←1 and go to PRESSED.
  - PRESSED: count ticks in `dur`, which saturates at `HOLD_TICKS`. On a falling edge, `dur`←0 and go to GAP.
  - GAP: count ticks in `dur`.
    - Rising edge: if count=15, go to ABORT; else count←count+1 and go to PRESSED.
    - `dur` reaches `GAP_TICKS`: go to EMIT.
  - EMIT: `digit`←count, `digit_valid`=1 for one cycle, then IDLE.
  - ABORT: `error`=1 for one cycle, then DRAIN.
  - DRAIN: wait for `btn_db` low, then IDLE. No digit is emitted.
- Width rules:
  - count is 4 bits and never wraps.
  - `dur` is `$clog2(max(GAP_TICKS, HOLD_TICKS)+1)` bits.
- `enable` deasserted in any state: next state is IDLE, count discarded, no pulses. A button already held when `enable` rises is ignored until released and pressed again.
- Simultaneous gap timeout and rising edge in the same cycle: the edge wins (stay in the burst).

## Timing
- Reset values: `digit`=0, `digit_valid`=0, `error`=0, `clear`=0, state IDLE, synchroniser and `btn_db`=0.
- Edge-to-`btn_db` latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycle.
- `digit_valid` asserts exactly 1 cycle after the GAP tick that reaches `GAP_TICKS`.
- `digit`, `digit_valid`, `error` and `clear` are registered outputs.
- `rst` mid-burst: immediate return to reset values. The partial burst is lost.

## Configuration
- `PRESS_DECODER_HOLD_CLEAR_EN` defined:
  - PRESSED reaching `HOLD_TICKS` pulses `clear` for one cycle, discards count, and goes to DRAIN.
  - No `digit_valid` for that burst.
- Undefined:
  - No `clear` port.
  - Holds count as ordinary presses; `dur` just saturates.

## Structure
- Package `press_decoder_pkg`:
  - state enum (IDLE, PRESSED, GAP, EMIT, ABORT, DRAIN);
  - `MAX_PRESSES`=15;
  - `dur` width function.
- One sub-module, `press_debounce`: synchroniser plus stable-count debouncer. Output is a level and a one-cycle rise/fall strobe.

## Test plan
Bench parameters: `TICK_CYCLES`=10, `DEBOUNCE_CYCLES`=4, `GAP_TICKS`=3, `HOLD_TICKS`=5.
- Reset: hold `rst`, toggle `btn_in` → all outputs 0. Release `rst` mid-burst → no `digit_valid`.
- Three clean presses of 20 cycles each with 15-cycle gaps, then release → one `digit_valid` with `digit`=3, arriving 1 cycle after the 3rd gap tick.
- Bounce: one press with 3-cycle glitches each side → `digit`=1. A single 3-cycle pulse alone → no output.
- 16 presses in one burst → `error` pulse on the 16th press, no `digit_valid`, then IDLE after release. The next single press gives `digit`=1.
- `enable` dropped after 2 presses → no outputs. Re-enable while the button is held → ignored until release, then the next press is counted.
- Macro defined: hold 60 cycles → `clear` pulse at tick 5, no `digit`. Macro undefined: the same hold → `digit`=1.

Source files
------------

// File: rtl/press_decoder_pkg.sv
// Shared types and sizing helpers for the lock-code press decoder.
package press_decoder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      GAP,
      EMIT,
      ABORT,
      DRAIN
   } state_t;

   localparam int MAX_PRESSES = 15;

   function automatic int dur_width(int gap_ticks, int hold_ticks);
      int m;
      m = (gap_ticks > hold_ticks) ? gap_ticks : hold_ticks;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/press_debounce.sv
// Two-flop synchroniser and stable-count debouncer for the raw button.
module press_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic hwclk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_db,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Level flips only once the disagreement has lasted the full window.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         sync   <= '0;
         cnt    <= '0;
         btn_db <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync <= {sync[0], btn_in};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == btn_db) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            cnt    <= '0;
            btn_db <= sync[1];
            rise   <= sync[1];
            fall   <= ~sync[1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/press_decoder.sv
// Counts debounced button presses in a burst and emits the count as a digit.
// Optional hold-to-clear: PRESS_DECODER_HOLD_CLEAR_EN.
module press_decoder
   import press_decoder_pkg::*;
#(
   parameter int TICK_CYCLES     = 1200000,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int GAP_TICKS       = 10,
   parameter int HOLD_TICKS      = 20
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic       enable,
   output logic [3:0] digit,
   output logic       digit_valid,
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
   output logic       clear,
`endif
   output logic       error
);

   localparam int DW = dur_width(GAP_TICKS, HOLD_TICKS);
   localparam int PW = $clog2(TICK_CYCLES + 1);

   logic          btn_db;
   logic          rise;
   logic          fall;
   logic          tick;
   logic [PW-1:0] presc;
   logic [DW-1:0] dur;
   logic [DW-1:0] dur_inc;
   logic [3:0]    count;
   state_t        state;

   press_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .hwclk (hwclk),
      .rst   (rst),
      .btn_in(btn_in),
      .btn_db(btn_db),
      .rise  (rise),
      .fall  (fall)
   );

   assign tick    = (presc == PW'(TICK_CYCLES - 1));
   assign dur_inc = dur + DW'(1);

   // Tick phase restarts on each button edge so durations align to edges.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (state == IDLE || rise || fall || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         dur         <= '0;
         digit       <= '0;
         digit_valid <= 1'b0;
         error       <= 1'b0;
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
         clear       <= 1'b0;
`endif
      end else begin
         digit_valid <= 1'b0;
         error       <= 1'b0;
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
         clear       <= 1'b0;
`endif
         if (!enable) begin
            state <= IDLE;
            count <= '0;
            dur   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (rise) begin
                     count <= 4'd1;
                     dur   <= '0;
                     state <= PRESSED;
                  end
               end
               PRESSED: begin
                  if (fall) begin
                     dur   <= '0;
                     state <= GAP;
                  end else if (tick && dur != DW'(HOLD_TICKS)) begin
                     dur <= dur_inc;
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
                     if (dur_inc == DW'(HOLD_TICKS)) begin
                        clear <= 1'b1;
                        count <= '0;
                        state <= DRAIN;
                     end
`endif
                  end
               end
               GAP: begin
                  // A new press beats a coincident gap timeout.
                  if (rise) begin
                     if (count == 4'(MAX_PRESSES)) begin
                        error <= 1'b1;
                        state <= ABORT;
                     end else begin
                        count <= count + 4'd1;
                        dur   <= '0;
                        state <= PRESSED;
                     end
                  end else if (tick) begin
                     dur <= dur_inc;
                     if (dur_inc >= DW'(GAP_TICKS)) begin
                        digit       <= count;
                        digit_valid <= 1'b1;
                        state       <= EMIT;
                     end
                  end
               end
               EMIT: begin
                  state <= IDLE;
               end
               ABORT: begin
                  count <= '0;
                  state <= DRAIN;
               end
               DRAIN: begin
                  if (!btn_db) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder: burst table plus corner-case sequences.
module tb_press_decoder;

   logic       hwclk;
   logic       rst;
   logic       btn_in;
   logic       enable;
   logic [3:0] digit;
   logic       digit_valid;
   logic       error;
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
   logic       clear;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_dv   = 0;
   int n_err  = 0;
   int n_clr  = 0;
   int dv_cyc = -1;
   int clr_cyc = -1;
   int rel    = 0;
   int prs    = 0;

   press_decoder #(
      .TICK_CYCLES    (10),
      .DEBOUNCE_CYCLES(4),
      .GAP_TICKS      (3),
      .HOLD_TICKS     (5)
   ) dut (
      .hwclk      (hwclk),
      .rst        (rst),
      .btn_in     (btn_in),
      .enable     (enable),
      .digit      (digit),
      .digit_valid(digit_valid),
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
      .clear      (clear),
`endif
      .error      (error)
   );

   initial hwclk = 1'b0;
   always #5 hwclk = ~hwclk;

   always @(posedge hwclk) begin
      cyc = cyc + 1;
      #2;
      if (digit_valid) begin
         n_dv   = n_dv + 1;
         dv_cyc = cyc;
      end
      if (error) n_err = n_err + 1;
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
      if (clear) begin
         n_clr   = n_clr + 1;
         clr_cyc = cyc;
      end
`endif
   end

   typedef struct {
      int         n;
      int         press_len;
      int         gap_len;
      logic [3:0] exp_digit;
      int         exp_dv;
      int         exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge hwclk);
      #1;
   endtask

   task automatic clr_stats();
      n_dv    = 0;
      n_err   = 0;
      n_clr   = 0;
      dv_cyc  = -1;
      clr_cyc = -1;
   endtask

   task automatic press(input int hi, input int lo);
      btn_in = 1'b1;
      prs    = cyc;
      cycles(hi);
      btn_in = 1'b0;
      rel    = cyc;
      cycles(lo);
   endtask

   initial begin
      vecs[0] = '{3,  20, 15, 4'd3,  1, 0};
      vecs[1] = '{1,  20, 15, 4'd1,  1, 0};
      vecs[2] = '{5,  12, 12, 4'd5,  1, 0};
      vecs[3] = '{15, 12, 12, 4'd15, 1, 0};
      vecs[4] = '{16, 12, 12, 4'd15, 0, 1};
      vecs[5] = '{2,  8,  8,  4'd2,  1, 0};

      rst    = 1'b1;
      btn_in = 1'b0;
      enable = 1'b1;
      cycles(2);

      // Button activity while reset is held must not disturb outputs.
      for (int i = 0; i < 4; i++) begin
         btn_in = ~btn_in;
         cycles(5);
         check("rst_digit", int'(digit), 0);
         check("rst_dv", int'(digit_valid), 0);
         check("rst_err", int'(error), 0);
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
         check("rst_clear", int'(clear), 0);
`endif
      end
      btn_in = 1'b0;
      rst    = 1'b0;
      cycles(20);
      clr_stats();

      // Reset arriving in the gap of a burst drops it.
      press(20, 15);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(60);
      check("rst_mid_dv", n_dv, 0);
      check("rst_mid_digit", int'(digit), 0);

      foreach (vecs[v]) begin
         clr_stats();
         for (int p = 0; p < vecs[v].n; p++) begin
            press(vecs[v].press_len,
                  (p == vecs[v].n - 1) ? 60 : vecs[v].gap_len);
         end
         check($sformatf("v%0d_dv", v), n_dv, vecs[v].exp_dv);
         check($sformatf("v%0d_err", v), n_err, vecs[v].exp_err);
         check($sformatf("v%0d_digit", v), int'(digit),
               int'(vecs[v].exp_digit));
         if (vecs[v].exp_dv != 0)
            check($sformatf("v%0d_dv_time", v), dv_cyc, rel + 38);
      end

      // Bounce on both sides of a single press.
      clr_stats();
      btn_in = 1'b1; cycles(3);
      btn_in = 1'b0; cycles(3);
      btn_in = 1'b1; cycles(20);
      btn_in = 1'b0; cycles(3);
      btn_in = 1'b1; cycles(3);
      btn_in = 1'b0;
      rel = cyc;
      cycles(60);
      check("bounce_dv", n_dv, 1);
      check("bounce_digit", int'(digit), 1);
      check("bounce_time", dv_cyc, rel + 38);

      // Lone 3-cycle glitch is filtered out.
      clr_stats();
      btn_in = 1'b1; cycles(3);
      btn_in = 1'b0; cycles(60);
      check("glitch_dv", n_dv, 0);
      check("glitch_err", n_err, 0);

      // Enable dropped mid-burst discards it.
      clr_stats();
      press(20, 15);
      press(20, 5);
      enable = 1'b0;
      cycles(60);
      check("en_drop_dv", n_dv, 0);
      check("en_drop_err", n_err, 0);

      // Held button at re-enable is ignored until re-pressed.
      btn_in = 1'b1; cycles(20);
      enable = 1'b1; cycles(20);
      btn_in = 1'b0; cycles(60);
      check("en_held_dv", n_dv, 0);
      press(20, 60);
      check("en_next_dv", n_dv, 1);
      check("en_next_digit", int'(digit), 1);

      // Long hold: clear under the hold option, else an ordinary press.
      clr_stats();
      press(60, 70);
`ifdef PRESS_DECODER_HOLD_CLEAR_EN
      check("hold_clear_cnt", n_clr, 1);
      check("hold_clear_time", clr_cyc, prs + 58);
      check("hold_dv", n_dv, 0);
`else
      check("hold_dv", n_dv, 1);
      check("hold_digit", int'(digit), 1);
      check("hold_time", dv_cyc, rel + 38);
`endif
      check("hold_err", n_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
